// File: rtl/mem_stage.sv
// MEM stage: latches EXE results and runs data-memory accesses over a req/ack bus.
// Ports: clk/rst, i_MEM_* from EXE and memory, o_MEM_* to WB, memory and hazard logic.
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_MEM_dmemWe,
    input  logic        i_MEM_regWe,
    input  logic        i_MEM_sByte,
    input  logic        i_MEM_sWRD,
    input  logic [4:0]  i_MEM_WRA,
    input  logic [31:0] i_MEM_aluOut,
    input  logic [31:0] i_MEM_rd2,
    input  logic        i_MEM_dmAck,
    input  logic [31:0] i_MEM_dmRdata,
    output logic        o_MEM_stall,
    output logic        o_MEM_regWe,
    output logic [4:0]  o_MEM_WRA,
    output logic [31:0] o_MEM_wbData,
    output logic        o_MEM_dmReq,
    output logic        o_MEM_dmWe,
    output logic [31:0] o_MEM_dmAddr,
    output logic [31:0] o_MEM_dmWdata,
    output logic [3:0]  o_MEM_dmBe,
    output logic        o_MEM_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dmem_we_q, dmem_we_d;
    logic               reg_we_q, reg_we_d;
    logic               s_byte_q, s_byte_d;
    logic               s_wrd_q, s_wrd_d;
    logic [4:0]         wra_q, wra_d;
    logic [31:0]        alu_q, alu_d;
    logic [31:0]        rd2_q, rd2_d;
    logic [31:0]        ld_q, ld_d;
    logic               err_q, err_d;

    logic               busy;
    logic [7:0]         rd_byte;
    logic [31:0]        ld_fmt;

    assign busy = (state_q == REQ);

    // Little-endian lane select for byte loads.
    always_comb begin
        rd_byte = i_MEM_dmRdata[7:0];
        case (alu_q[1:0])
            2'd0: rd_byte = i_MEM_dmRdata[7:0];
            2'd1: rd_byte = i_MEM_dmRdata[15:8];
            2'd2: rd_byte = i_MEM_dmRdata[23:16];
            2'd3: rd_byte = i_MEM_dmRdata[31:24];
            default: rd_byte = i_MEM_dmRdata[7:0];
        endcase
        ld_fmt = s_byte_q ? {{24{rd_byte[7]}}, rd_byte} : i_MEM_dmRdata;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dmem_we_d = dmem_we_q;
        reg_we_d  = reg_we_q;
        s_byte_d  = s_byte_q;
        s_wrd_d   = s_wrd_q;
        wra_d     = wra_q;
        alu_d     = alu_q;
        rd2_d     = rd2_q;
        ld_d      = ld_q;
        err_d     = err_q;

        if (!busy) begin
            // IDLE and DONE both accept the next instruction.
            dmem_we_d = i_MEM_dmemWe;
            reg_we_d  = i_MEM_regWe;
            s_byte_d  = i_MEM_sByte;
            s_wrd_d   = i_MEM_sWRD;
            wra_d     = i_MEM_WRA;
            alu_d     = i_MEM_aluOut;
            rd2_d     = i_MEM_rd2;
            cnt_d     = '0;
            state_d   = (i_MEM_dmemWe | i_MEM_sWRD) ? REQ : IDLE;
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (i_MEM_dmAck) begin
                ld_d    = ld_fmt;
                state_d = DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                // Last allowed REQ cycle without ack: abort.
                err_d   = 1'b1;
                ld_d    = '0;
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dmem_we_q <= 1'b0;
            reg_we_q  <= 1'b0;
            s_byte_q  <= 1'b0;
            s_wrd_q   <= 1'b0;
            wra_q     <= '0;
            alu_q     <= '0;
            rd2_q     <= '0;
            ld_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dmem_we_q <= dmem_we_d;
            reg_we_q  <= reg_we_d;
            s_byte_q  <= s_byte_d;
            s_wrd_q   <= s_wrd_d;
            wra_q     <= wra_d;
            alu_q     <= alu_d;
            rd2_q     <= rd2_d;
            ld_q      <= ld_d;
            err_q     <= err_d;
        end
    end

    // Bus signals are only driven while a request is outstanding.
    always_comb begin
        o_MEM_stall   = busy;
        o_MEM_dmReq   = busy;
        o_MEM_dmWe    = busy & dmem_we_q;
        o_MEM_dmAddr  = '0;
        o_MEM_dmBe    = '0;
        o_MEM_dmWdata = '0;
        if (busy) begin
            if (s_byte_q) begin
                o_MEM_dmAddr  = alu_q;
                o_MEM_dmBe    = 4'b0001 << alu_q[1:0];
                o_MEM_dmWdata = {4{rd2_q[7:0]}};
            end else begin
                o_MEM_dmAddr  = {alu_q[31:2], 2'b00};
                o_MEM_dmBe    = 4'b1111;
                o_MEM_dmWdata = rd2_q;
            end
        end
        o_MEM_regWe  = reg_we_q & ~busy;
        o_MEM_WRA    = wra_q;
        // Stores win over loads when both flags are set.
        o_MEM_wbData = (s_wrd_q & ~dmem_we_q) ? ld_q : alu_q;
        o_MEM_err    = err_q;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
// Each task drives one scenario and checks outputs 1ns after the rising edge.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        i_MEM_dmemWe;
    logic        i_MEM_regWe;
    logic        i_MEM_sByte;
    logic        i_MEM_sWRD;
    logic [4:0]  i_MEM_WRA;
    logic [31:0] i_MEM_aluOut;
    logic [31:0] i_MEM_rd2;
    logic        i_MEM_dmAck;
    logic [31:0] i_MEM_dmRdata;
    logic        o_MEM_stall;
    logic        o_MEM_regWe;
    logic [4:0]  o_MEM_WRA;
    logic [31:0] o_MEM_wbData;
    logic        o_MEM_dmReq;
    logic        o_MEM_dmWe;
    logic [31:0] o_MEM_dmAddr;
    logic [31:0] o_MEM_dmWdata;
    logic [3:0]  o_MEM_dmBe;
    logic        o_MEM_err;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    mem_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_MEM_dmemWe  (i_MEM_dmemWe),
        .i_MEM_regWe   (i_MEM_regWe),
        .i_MEM_sByte   (i_MEM_sByte),
        .i_MEM_sWRD    (i_MEM_sWRD),
        .i_MEM_WRA     (i_MEM_WRA),
        .i_MEM_aluOut  (i_MEM_aluOut),
        .i_MEM_rd2     (i_MEM_rd2),
        .i_MEM_dmAck   (i_MEM_dmAck),
        .i_MEM_dmRdata (i_MEM_dmRdata),
        .o_MEM_stall   (o_MEM_stall),
        .o_MEM_regWe   (o_MEM_regWe),
        .o_MEM_WRA     (o_MEM_WRA),
        .o_MEM_wbData  (o_MEM_wbData),
        .o_MEM_dmReq   (o_MEM_dmReq),
        .o_MEM_dmWe    (o_MEM_dmWe),
        .o_MEM_dmAddr  (o_MEM_dmAddr),
        .o_MEM_dmWdata (o_MEM_dmWdata),
        .o_MEM_dmBe    (o_MEM_dmBe),
        .o_MEM_err     (o_MEM_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic rwe, input logic sb,
                         input logic swrd, input logic [4:0] wra,
                         input logic [31:0] alu, input logic [31:0] rd2);
        i_MEM_dmemWe = we;
        i_MEM_regWe  = rwe;
        i_MEM_sByte  = sb;
        i_MEM_sWRD   = swrd;
        i_MEM_WRA    = wra;
        i_MEM_aluOut = alu;
        i_MEM_rd2    = rd2;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bubble();
        i_MEM_dmAck   = 1'b0;
        i_MEM_dmRdata = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        tot_cnt++;
        if ({o_MEM_stall, o_MEM_dmReq, o_MEM_regWe, o_MEM_dmWe, o_MEM_err} !== 5'b0)
            $display("FAIL rst_ctrl got %b exp 00000",
                {o_MEM_stall, o_MEM_dmReq, o_MEM_regWe, o_MEM_dmWe, o_MEM_err});
        else pass_cnt++;
        tot_cnt++;
        if ({o_MEM_wbData, o_MEM_dmAddr, o_MEM_dmWdata, o_MEM_dmBe, o_MEM_WRA} !== 105'b0)
            $display("FAIL rst_data got %h %h %h %h %h exp all 0", o_MEM_wbData,
                o_MEM_dmAddr, o_MEM_dmWdata, o_MEM_dmBe, o_MEM_WRA);
        else pass_cnt++;
    endtask

    task automatic test_alu();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'h0);
        tick();
        tot_cnt++;
        if ({o_MEM_stall, o_MEM_dmReq, o_MEM_regWe} !== 3'b001)
            $display("FAIL alu_ctrl got %b exp 001", {o_MEM_stall, o_MEM_dmReq, o_MEM_regWe});
        else pass_cnt++;
        tot_cnt++;
        if (o_MEM_wbData !== 32'h1234) $display("FAIL alu_wb got %h exp 00001234", o_MEM_wbData);
        else pass_cnt++;
        tot_cnt++;
        if (o_MEM_WRA !== 5'd5) $display("FAIL alu_wra got %0d exp 5", o_MEM_WRA);
        else pass_cnt++;
        bubble();
        tick();
    endtask

    task automatic test_word_store();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0103, 32'hDEAD_BEEF);
        tick();
        // Different inputs while stalled must not disturb the held access.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'hFFFF_FFFF, 32'h1111_1111);
        for (int i = 0; i < 3; i++) begin
            tot_cnt++;
            if ({o_MEM_dmReq, o_MEM_stall, o_MEM_dmWe, o_MEM_regWe} !== 4'b1110)
                $display("FAIL wst_ctrl%0d got %b exp 1110", i,
                    {o_MEM_dmReq, o_MEM_stall, o_MEM_dmWe, o_MEM_regWe});
            else pass_cnt++;
            tot_cnt++;
            if (o_MEM_dmAddr !== 32'h100 || o_MEM_dmBe !== 4'hF || o_MEM_dmWdata !== 32'hDEAD_BEEF)
                $display("FAIL wst_bus%0d got %h %h %h exp 00000100 f deadbeef", i,
                    o_MEM_dmAddr, o_MEM_dmBe, o_MEM_dmWdata);
            else pass_cnt++;
            if (i == 2) begin
                i_MEM_dmAck = 1'b1;
                bubble();
            end
            tick();
        end
        i_MEM_dmAck = 1'b0;
        tot_cnt++;
        if ({o_MEM_stall, o_MEM_dmReq, o_MEM_dmWe} !== 3'b000)
            $display("FAIL wst_done got %b exp 000", {o_MEM_stall, o_MEM_dmReq, o_MEM_dmWe});
        else pass_cnt++;
        tot_cnt++;
        if (o_MEM_wbData !== 32'h103) $display("FAIL wst_wb got %h exp 00000103", o_MEM_wbData);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_byte_load();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0000_0202, 32'h0);
        tick();
        bubble();
        tot_cnt++;
        if (o_MEM_dmAddr !== 32'h202 || o_MEM_dmBe !== 4'b0100 || o_MEM_dmWe !== 1'b0)
            $display("FAIL bld_bus got %h %b %b exp 00000202 0100 0",
                o_MEM_dmAddr, o_MEM_dmBe, o_MEM_dmWe);
        else pass_cnt++;
        tot_cnt++;
        if ({o_MEM_stall, o_MEM_regWe} !== 2'b10)
            $display("FAIL bld_req got %b exp 10", {o_MEM_stall, o_MEM_regWe});
        else pass_cnt++;
        i_MEM_dmAck   = 1'b1;
        i_MEM_dmRdata = 32'h0080_0000;
        tick();
        i_MEM_dmAck   = 1'b0;
        i_MEM_dmRdata = 32'h0;
        tot_cnt++;
        if (o_MEM_wbData !== 32'hFFFF_FF80) $display("FAIL bld_wb got %h exp ffffff80", o_MEM_wbData);
        else pass_cnt++;
        tot_cnt++;
        if ({o_MEM_regWe, o_MEM_stall, o_MEM_WRA} !== {1'b1, 1'b0, 5'd7})
            $display("FAIL bld_wbctl got %b %b %0d exp 1 0 7", o_MEM_regWe, o_MEM_stall, o_MEM_WRA);
        else pass_cnt++;
        tick();
        // Lane 3, positive byte.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 32'h0000_0403, 32'h0);
        tick();
        bubble();
        i_MEM_dmAck   = 1'b1;
        i_MEM_dmRdata = 32'h7F00_00FF;
        tick();
        i_MEM_dmAck = 1'b0;
        tot_cnt++;
        if (o_MEM_wbData !== 32'h0000_007F) $display("FAIL bld3_wb got %h exp 0000007f", o_MEM_wbData);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_byte_store();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0301, 32'h0000_00AB);
        tick();
        bubble();
        tot_cnt++;
        if (o_MEM_dmBe !== 4'b0010 || o_MEM_dmWdata !== 32'hABAB_ABAB || o_MEM_dmAddr !== 32'h301)
            $display("FAIL bst_bus got %b %h %h exp 0010 abababab 00000301",
                o_MEM_dmBe, o_MEM_dmWdata, o_MEM_dmAddr);
        else pass_cnt++;
        i_MEM_dmAck = 1'b1;
        tick();
        i_MEM_dmAck = 1'b0;
        tick();
        // Both flags set: treated as a store, writeback is aluOut.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0500, 32'h1);
        tick();
        bubble();
        tot_cnt++;
        if (o_MEM_dmWe !== 1'b1) $display("FAIL prio_we got %b exp 1", o_MEM_dmWe);
        else pass_cnt++;
        i_MEM_dmAck   = 1'b1;
        i_MEM_dmRdata = 32'hCAFE_BABE;
        tick();
        i_MEM_dmAck = 1'b0;
        tot_cnt++;
        if (o_MEM_wbData !== 32'h500 || o_MEM_regWe !== 1'b1)
            $display("FAIL prio_wb got %h %b exp 00000500 1", o_MEM_wbData, o_MEM_regWe);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        tot_cnt++;
        if (o_MEM_err !== 1'b0) $display("FAIL pre_err got %b exp 0", o_MEM_err);
        else pass_cnt++;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd6, 32'h0000_0600, 32'h0);
        tick();
        bubble();
        n = 0;
        while (o_MEM_dmReq && n < 40) begin
            n++;
            tick();
        end
        tot_cnt++;
        if (n !== 16) $display("FAIL to_cycles got %0d exp 16", n);
        else pass_cnt++;
        tot_cnt++;
        if (o_MEM_err !== 1'b1 || o_MEM_wbData !== 32'h0 || o_MEM_stall !== 1'b0)
            $display("FAIL to_done got %b %h %b exp 1 00000000 0", o_MEM_err, o_MEM_wbData, o_MEM_stall);
        else pass_cnt++;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 32'h0000_0077, 32'h0);
        tick();
        bubble();
        tot_cnt++;
        if (o_MEM_wbData !== 32'h77 || o_MEM_err !== 1'b1)
            $display("FAIL to_sticky got %h %b exp 00000077 1", o_MEM_wbData, o_MEM_err);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0700, 32'h0);
        tick();
        bubble();
        tick();
        tot_cnt++;
        if (o_MEM_dmReq !== 1'b1) $display("FAIL rm_req2 got %b exp 1", o_MEM_dmReq);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tot_cnt++;
        if ({o_MEM_dmReq, o_MEM_stall, o_MEM_regWe, o_MEM_err} !== 4'b0 ||
            o_MEM_wbData !== 32'h0 || o_MEM_dmAddr !== 32'h0 || o_MEM_dmBe !== 4'h0)
            $display("FAIL rm_zero got %b%b%b%b %h %h %h exp 0000 0 0 0", o_MEM_dmReq,
                o_MEM_stall, o_MEM_regWe, o_MEM_err, o_MEM_wbData, o_MEM_dmAddr, o_MEM_dmBe);
        else pass_cnt++;
        i_MEM_dmAck   = 1'b1;
        i_MEM_dmRdata = 32'h5555_AAAA;
        tick();
        i_MEM_dmAck = 1'b0;
        tot_cnt++;
        if ({o_MEM_dmReq, o_MEM_stall, o_MEM_regWe} !== 3'b0 || o_MEM_wbData !== 32'h0)
            $display("FAIL rm_stray got %b %h exp 000 00000000",
                {o_MEM_dmReq, o_MEM_stall, o_MEM_regWe}, o_MEM_wbData);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd10, 32'h0000_00A1, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd11, 32'h0000_00B2, 32'h0);
        tot_cnt++;
        if (o_MEM_wbData !== 32'hA1 || o_MEM_WRA !== 5'd10)
            $display("FAIL b2b_a got %h %0d exp 000000a1 10", o_MEM_wbData, o_MEM_WRA);
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (o_MEM_wbData !== 32'hB2 || o_MEM_WRA !== 5'd11)
            $display("FAIL b2b_b got %h %0d exp 000000b2 11", o_MEM_wbData, o_MEM_WRA);
        else pass_cnt++;
        // Word load followed by an ALU op waiting at the inputs.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0044, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 32'h0000_0099, 32'h0);
        i_MEM_dmAck   = 1'b1;
        i_MEM_dmRdata = 32'h1234_5678;
        tick();
        i_MEM_dmAck = 1'b0;
        tot_cnt++;
        if (o_MEM_wbData !== 32'h1234_5678 || o_MEM_WRA !== 5'd3 || o_MEM_regWe !== 1'b1)
            $display("FAIL b2b_ld got %h %0d %b exp 12345678 3 1", o_MEM_wbData, o_MEM_WRA, o_MEM_regWe);
        else pass_cnt++;
        tick();
        bubble();
        tot_cnt++;
        if (o_MEM_wbData !== 32'h99 || o_MEM_WRA !== 5'd9 || o_MEM_stall !== 1'b0)
            $display("FAIL b2b_alu got %h %0d %b exp 00000099 9 0", o_MEM_wbData, o_MEM_WRA, o_MEM_stall);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_word_store();
        test_byte_load();
        test_byte_store();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
